// File: rtl/mem_access_unit.sv
// mem_access_unit: sub-word load/store controller sitting in front of a
// word-only data memory. Loads and SW complete in the request cycle; SB/SH
// are performed as a read (stalling the pipeline) followed by a merged write.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    input  logic [31:0] dm_rdata,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        align_err
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef enum logic {
        IDLE,
        MERGE_WR
    } state_t;

    state_t      state;
    logic [31:0] merge_q;
    logic [31:0] addr_q;
    logic [31:0] pc_q;

    logic        need_word;
    logic        need_half;
    logic        misaligned;
    logic        in_merge;
    logic        start_merge;
    logic [4:0]  shamt;
    logic [31:0] word_addr;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Decode alignment requirements and build the lane-merged store word
    always_comb begin
        need_word   = (mem_op == OP_LW) || (mem_op == OP_SW);
        need_half   = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        misaligned  = (need_word && (addr[1:0] != 2'b00)) || (need_half && addr[0]);
        in_merge    = (state == MERGE_WR) && !reset;
        start_merge = !in_merge && !misaligned && ((mem_op == OP_SH) || (mem_op == OP_SB));
        word_addr   = {addr[31:2], 2'b00};
        shamt       = {addr[1:0], 3'b000};
        shifted     = dm_rdata >> shamt;
        if (mem_op == OP_SH) begin
            lane_mask = 32'h0000_FFFF << shamt;
            lane_data = {16'h0000, wdata[15:0]} << shamt;
        end else begin
            lane_mask = 32'h0000_00FF << shamt;
            lane_data = {24'h000000, wdata[7:0]} << shamt;
        end
        merged = (dm_rdata & ~lane_mask) | lane_data;
    end

    // Drive memory commands, load result and stall from the current op and state
    always_comb begin
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = word_addr;
        dm_wdata  = wdata;
        dm_pc     = pc;
        load_data = 32'h0;
        stall     = 1'b0;
        align_err = 1'b0;
        if (in_merge) begin
            dm_write = 1'b1;
            dm_addr  = addr_q;
            dm_wdata = merge_q;
            dm_pc    = pc_q;
        end else if (misaligned) begin
            align_err = 1'b1;
        end else begin
            case (mem_op)
                OP_LW: begin
                    dm_read   = 1'b1;
                    load_data = dm_rdata;
                end
                OP_LH: begin
                    dm_read   = 1'b1;
                    load_data = {{16{shifted[15]}}, shifted[15:0]};
                end
                OP_LHU: begin
                    dm_read   = 1'b1;
                    load_data = {16'h0000, shifted[15:0]};
                end
                OP_LB: begin
                    dm_read   = 1'b1;
                    load_data = {{24{shifted[7]}}, shifted[7:0]};
                end
                OP_LBU: begin
                    dm_read   = 1'b1;
                    load_data = {24'h000000, shifted[7:0]};
                end
                OP_SW: begin
                    dm_write = 1'b1;
                end
                OP_SH, OP_SB: begin
                    dm_read = 1'b1;
                    stall   = 1'b1;
                end
                default: begin
                    dm_read = 1'b0;
                end
            endcase
        end
        if (reset) begin
            dm_write = 1'b0;
        end
    end

    // Read-modify-write sequencer: capture the merged word, then write it next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            merge_q <= 32'h0;
            addr_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_merge) begin
                        merge_q <= merged;
                        addr_q  <= word_addr;
                        pc_q    <= pc;
                        state   <= MERGE_WR;
                    end
                end
                MERGE_WR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sub-word memory access controller in the MEM stage, directly upstream of the word-only data memory. Translates the pipeline's load/store opcode, byte address and store data into word-aligned data-memory read/write commands, extends loaded bytes/halfwords, and implements SB/SH as a two-cycle read-modify-write while stalling the pipeline. Flags misaligned accesses and suppresses them.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_op  in  4  0 NOP, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB, 9–15 treated as NOP
- addr  in  32  byte address from EX/MEM register
- wdata  in  32  store data (rt value); SH uses [15:0], SB uses [7:0]
- pc  in  32  instruction PC, passed through for the memory's write log
- dm_rdata  in  32  word read from data memory (combinational)
- dm_read  out  1  data-memory read enable
- dm_write  out  1  data-memory write enable (memory writes on posedge clk)
- dm_addr  out  32  word address, {addr[31:2],2'b00} or latched copy
- dm_wdata  out  32  word to write
- dm_pc  out  32  PC for the write log
- load_data  out  32  extended load result to MEM/WB
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- align_err  out  1  current access misaligned, suppressed

## Operation
- Byte lanes little-endian: addr[1:0]=0 selects bits [7:0]; halfword addr[1]=0 selects [15:0].
- Alignment: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0; LB/LBU/SB always aligned. Misaligned → align_err=1, dm_read=dm_write=0, load_data=0, stall=0, state unchanged.
- Loads (single cycle, combinational): dm_read=1; LW full word; LH/LB sign-extend selected lane; LHU/LBU zero-extend.
- SW (single cycle): dm_write=1, dm_wdata=wdata.
- SH/SB: FSM, states IDLE, MERGE_WR.
  - IDLE with aligned SH/SB: dm_read=1, dm_write=0, stall=1. At posedge latch merged word (dm_rdata with selected lane replaced by wdata lane), word address and pc into merge_q/addr_q/pc_q; go MERGE_WR.
  - MERGE_WR: dm_write=1, dm_addr=addr_q, dm_wdata=merge_q, dm_pc=pc_q, stall=0, dm_read=0, mem_op ignored. At posedge memory commits; go IDLE; pipeline advances.
  - All other ops keep FSM in IDLE.
- NOP: all enables 0, load_data=0.
- dm_pc=pc except in MERGE_WR.

## Timing
- Reset: state IDLE, merge_q=addr_q=pc_q=0. Outputs during reset cycle combinational on inputs with state IDLE; dm_write forced 0 while reset=1.
- Reset in MERGE_WR: no write issued that cycle, next state IDLE, merge lost.
- Load latency 0 cycles (same cycle as request); SW commits at end of request cycle; SH/SB commit at end of second cycle, stall high exactly one cycle.
- Upstream holds mem_op/addr/wdata stable while stall=1; unit ignores them in MERGE_WR regardless.
- Back-to-back SB, SB: each takes 2 cycles; second's read occurs after first's write, so sees updated word.
- SB immediately followed by LW same word: LW reads post-write data.

## Test plan
- Memory word 0x10 = 0x11223344; LB addr 0x13 → load_data 0x00000011; LH addr 0x12 → 0x00001122; LBU addr 0x10 with word 0x000000F0 → 0x000000F0, LB → 0xFFFFFFF0.
- SW 0xDEADBEEF to 0x20 → dm_write=1 one cycle, stall 0, subsequent LW 0x20 returns 0xDEADBEEF.
- Word 0x30 = 0xAABBCCDD; SB wdata 0x12345677 to 0x31 → stall 1 for 1 cycle, then dm_write with dm_addr 0x30, dm_wdata 0xAABB77DD; SH 0xBEEF to 0x32 next → 0xBEEF77DD.
- LW addr 0x41, SH addr 0x43 → align_err=1, no dm_write, stall 0, memory unchanged.
- SB to 0x50 with reset asserted in MERGE_WR cycle → no write, state IDLE, word 0x50 unchanged (0).
- Two consecutive SB to 0x60 (addr 0x60 data 0xAA, 0x61 data 0xBB) from 0 → final word 0x0000BBAA, total 4 cycles, 2 stall cycles.
